// File: rtl/shift_pkg.sv
// Shared definitions for the serial right/left shift unit: state encoding,
// default widths and the set of supported per-cycle step sizes.
package shift_pkg;

    localparam int XLEN_DEF = 32;
    localparam int SHAMT_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Supported STEP_BITS values: 1, 2 and 4.
    function automatic bit step_legal(input int s);
        return (s == 1) || (s == 2) || (s == 4);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single step of the serial shifter: moves the operand by k
// positions (0..STEP_BITS). Left shifts exist only when SHIFT_LEFT_EN is defined.
module shift_step
    import shift_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int STEP_BITS = 1
) (
    input  logic [XLEN-1:0]                  op,
    input  logic [$clog2(STEP_BITS+1)-1:0]   k,
    input  logic                             fill,
`ifdef SHIFT_LEFT_EN
    input  logic                             dir,
`endif
    output logic [XLEN-1:0]                  res
);

    localparam int IW = $clog2(XLEN + STEP_BITS);

    logic [XLEN+STEP_BITS-1:0] ext_r;
    logic [IW-1:0]             idx_r;

    // Window into the operand extended with fill bits; the window start is k.
    assign ext_r = {{STEP_BITS{fill}}, op};
    assign idx_r = IW'(k);

`ifdef SHIFT_LEFT_EN
    logic [XLEN+STEP_BITS-1:0] ext_l;
    logic [IW-1:0]             idx_l;

    assign ext_l = {op, {STEP_BITS{1'b0}}};
    assign idx_l = IW'(STEP_BITS) - IW'(k);
    assign res   = dir ? ext_l[idx_l +: XLEN] : ext_r[idx_r +: XLEN];
`else
    assign res   = ext_r[idx_r +: XLEN];
`endif

endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle SRL/SRA unit shifting STEP_BITS per cycle behind a valid/ready
// handshake. Define SHIFT_LEFT_EN to add a dir_i port for zero-filled left shifts.
module shift_right_seq
    import shift_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int STEP_BITS = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [XLEN-1:0]    data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               arith_i,
`ifdef SHIFT_LEFT_EN
    input  logic               dir_i,
`endif
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [XLEN-1:0]    data_o,
    output logic               busy_o
);

    localparam int                 KW     = $clog2(STEP_BITS + 1);
    localparam logic [SHAMT_W-1:0] STEP_R = SHAMT_W'(STEP_BITS);

    if (!step_legal(STEP_BITS)) begin : g_bad_step
        $error("shift_right_seq: STEP_BITS must be 1, 2 or 4");
    end

    state_e             state;
    logic [XLEN-1:0]    work;
    logic [SHAMT_W-1:0] rem;
    logic               fill_q;
    logic [XLEN-1:0]    stepped;
    logic [KW-1:0]      k;
    logic [SHAMT_W-1:0] rem_nxt;
`ifdef SHIFT_LEFT_EN
    logic               dir_q;
`endif

    assign k       = (rem < STEP_R) ? KW'(rem) : KW'(STEP_BITS);
    assign rem_nxt = rem - SHAMT_W'(k);

    shift_step #(.XLEN(XLEN), .STEP_BITS(STEP_BITS)) u_step (
        .op   (work),
        .k    (k),
        .fill (fill_q),
`ifdef SHIFT_LEFT_EN
        .dir  (dir_q),
`endif
        .res  (stepped)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            work        <= '0;
            rem         <= '0;
            fill_q      <= 1'b0;
`ifdef SHIFT_LEFT_EN
            dir_q       <= 1'b0;
`endif
            data_o      <= '0;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            busy_o      <= 1'b0;
        end else if (flush_i) begin
            state       <= IDLE;
            work        <= '0;
            rem         <= '0;
            data_o      <= '0;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid_i) begin
                    work       <= data_i;
                    rem        <= shamt_i;
`ifdef SHIFT_LEFT_EN
                    dir_q      <= dir_i;
                    fill_q     <= arith_i & data_i[XLEN-1] & ~dir_i;
`else
                    fill_q     <= arith_i & data_i[XLEN-1];
`endif
                    in_ready_o <= 1'b0;
                    busy_o     <= 1'b1;
                    if (shamt_i == '0) begin
                        state       <= DONE;
                        data_o      <= data_i;
                        out_valid_o <= 1'b1;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= stepped;
                    rem  <= rem_nxt;
                    // Result is published on the same edge the last step lands.
                    if (rem_nxt == '0) begin
                        state       <= DONE;
                        data_o      <= stepped;
                        out_valid_o <= 1'b1;
                    end
                end
                DONE: if (out_ready_i) begin
                    state       <= IDLE;
                    data_o      <= '0;
                    out_valid_o <= 1'b0;
                    in_ready_o  <= 1'b1;
                    busy_o      <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    out_valid_o <= 1'b0;
                    in_ready_o  <= 1'b1;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule
